// File: rtl/area_hit_counter_pkg.sv
// Shared constants, state encoding and helpers for the area hit counter.
package area_hit_counter_pkg;

    localparam int unsigned COORD_W     = 8;   // converter sample width
    localparam int unsigned SUM_W       = 9;   // |x|+|y| without wrap
    localparam int unsigned IDX_W       = 8;   // sample index, covers 1..255 samples
    localparam int unsigned HALF_SIDE   = 48;  // square half-side, inclusive
    localparam int unsigned DIAG_RADIUS = 64;  // diamond radius, inclusive

    typedef enum logic [1:0] {
        S_SOC = 2'd0,
        S_EOC = 2'd1,
        S_OUT = 2'd2,
        S_ACK = 2'd3
    } state_t;

    // Magnitude of a two's complement coordinate; |-128| = 128 fits unsigned.
    function automatic logic [COORD_W-1:0] abs_coord(input logic [COORD_W-1:0] v);
        return v[COORD_W-1] ? COORD_W'((~v) + COORD_W'(1)) : v;
    endfunction

endpackage

// File: rtl/area_classifier.sv
// Point-in-area test: inside when the point lies in exactly one of the
// square (|x|,|y| <= HALF_SIDE) and the diamond (|x|+|y| <= DIAG_RADIUS).
// Ports:
//   x_i, y_i  : two's complement coordinates
//   inside_c  : combinational classification result
module area_classifier
    import area_hit_counter_pkg::*;
(
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               inside_c
);

    logic [COORD_W-1:0] ax;
    logic [COORD_W-1:0] ay;
    logic [SUM_W-1:0]   sum;
    logic               in_sq;
    logic               in_diam;

    always_comb begin
        ax       = abs_coord(x_i);
        ay       = abs_coord(y_i);
        // 9-bit sum so 128+128 does not wrap back into the diamond
        sum      = SUM_W'(ax) + SUM_W'(ay);
        in_sq    = (ax <= COORD_W'(HALF_SIDE)) && (ay <= COORD_W'(HALF_SIDE));
        in_diam  = (sum <= SUM_W'(DIAG_RADIUS));
        inside_c = in_sq ^ in_diam;
    end

endmodule

// File: rtl/area_hit_counter.sv
// Batch controller: acquires N_SAMPLES points from the X/Y converters,
// counts the points inside the area and hands the count to a consumer.
// Ports:
//   clock, reset_        : clock (posedge), asynchronous active-low reset
//   soc_x, soc_y         : start of conversion (identical)
//   eoc_x, eoc_y         : end of conversion, 1 = idle/done
//   x, y                 : two's complement coordinates
//   dav_                 : data valid, active low
//   rfd                  : consumer ready for data
//   count                : hits in last batch, valid while dav_ = 0
// N_SAMPLES must be 1..255 and no greater than 2**CW-1 so acc never wraps.
module area_hit_counter
    import area_hit_counter_pkg::*;
#(
    parameter int unsigned N_SAMPLES = 8,
    parameter int unsigned CW        = 8
) (
    input  logic               clock,
    input  logic               reset_,
    output logic               soc_x,
    input  logic               eoc_x,
    input  logic [COORD_W-1:0] x,
    output logic               soc_y,
    input  logic               eoc_y,
    input  logic [COORD_W-1:0] y,
    output logic               dav_,
    input  logic               rfd,
    output logic [CW-1:0]      count
);

    state_t           state_q, state_d;
    logic             soc_q, soc_d;
    logic             dav_n_q, dav_n_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             inside_c;
    logic [CW-1:0]    acc_plus;
    logic             last_sample;
    logic             both_done;

    area_classifier u_classifier (
        .x_i      (x),
        .y_i      (y),
        .inside_c (inside_c)
    );

    assign acc_plus    = acc_q + CW'(inside_c);
    assign last_sample = (idx_q == IDX_W'(N_SAMPLES - 1));
    assign both_done   = eoc_x & eoc_y;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_SOC;
            soc_q   <= 1'b0;
            dav_n_q <= 1'b1;
            count_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
            dav_n_q <= dav_n_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        soc_d   = soc_q;
        dav_n_d = dav_n_q;
        count_d = count_q;
        acc_d   = acc_q;
        idx_d   = idx_q;

        unique case (state_q)
            S_SOC: begin
                soc_d = 1'b1;
                if (!eoc_x && !eoc_y) begin
                    state_d = S_EOC;
                end
            end
            S_EOC: begin
                soc_d = 1'b0;
                // Coordinates are only trusted once both converters are done
                if (both_done) begin
                    acc_d = acc_plus;
                    if (last_sample) begin
                        count_d = acc_plus;
                        state_d = S_OUT;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_SOC;
                    end
                end
            end
            S_OUT: begin
                dav_n_d = 1'b0;
                if (!rfd) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                dav_n_d = 1'b1;
                if (rfd) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_SOC;
                end
            end
            default: begin
                state_d = S_SOC;
            end
        endcase
    end

    assign soc_x = soc_q;
    assign soc_y = soc_q;
    assign dav_  = dav_n_q;
    assign count = count_q;

endmodule

// File: tb/tb_area_hit_counter.sv
// Directed bench for area_hit_counter: a 4-sample instance driven step by
// step and a 255-sample instance driven by an auto-responding converter.
module tb_area_hit_counter;

    logic       clock;
    logic       reset_;

    logic       soc_x, soc_y, eoc_x, eoc_y, dav_, rfd;
    logic [7:0] x, y, count;

    logic       soc_x_b, soc_y_b, eoc_x_b, eoc_y_b, dav_b, rfd_b;
    logic [7:0] x_b, y_b, count_b;
    logic       en_b;

    int n_checks;
    int n_errors;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b[$];
    int px[4];
    int py[4];

    area_hit_counter #(.N_SAMPLES(4), .CW(8)) dut (
        .clock(clock), .reset_(reset_),
        .soc_x(soc_x), .eoc_x(eoc_x), .x(x),
        .soc_y(soc_y), .eoc_y(eoc_y), .y(y),
        .dav_(dav_), .rfd(rfd), .count(count)
    );

    area_hit_counter #(.N_SAMPLES(255), .CW(8)) dut_b (
        .clock(clock), .reset_(reset_),
        .soc_x(soc_x_b), .eoc_x(eoc_x_b), .x(x_b),
        .soc_y(soc_y_b), .eoc_y(eoc_y_b), .y(y_b),
        .dav_(dav_b), .rfd(rfd_b), .count(count_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference point test written from the geometric definition
    function automatic int ref_inside(input int xv, input int yv);
        int ax, ay;
        bit sq, diam;
        ax   = (xv < 0) ? -xv : xv;
        ay   = (yv < 0) ? -yv : yv;
        sq   = (ax <= 48) && (ay <= 48);
        diam = (ax + ay) <= 64;
        return (sq != diam) ? 1 : 0;
    endfunction

    task automatic wait_soc();
        int k;
        k = 0;
        while (soc_x !== 1'b1 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("soc_timeout", 32'(soc_x), 32'd1);
    endtask

    // One conversion: eoc_x may lead eoc_y by lag clocks with x scrambled meanwhile
    task automatic sample_pt(input int xv, input int yv, input int lag);
        wait_soc();
        eoc_x = 1'b0;
        eoc_y = 1'b0;
        @(negedge clock);
        check("soc_pair", 32'(soc_y), 32'(soc_x));
        if (lag == 0) begin
            x = 8'(xv);
            y = 8'(yv);
            eoc_x = 1'b1;
            eoc_y = 1'b1;
        end else begin
            eoc_x = 1'b1;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            for (int i = 0; i < lag; i++) begin
                @(negedge clock);
                check("soc_low_wait", 32'(soc_x), 32'd0);
                x = 8'($urandom_range(0, 255));
            end
            x = 8'(xv);
            y = 8'(yv);
            eoc_y = 1'b1;
        end
        @(negedge clock);
    endtask

    // Consumer side: pop expected count at dav_=0, hold rfd=1, then pulse rfd=0
    task automatic finish_batch(input int hold);
        int k;
        logic [7:0] e;
        k = 0;
        while (dav_ !== 1'b0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        check("dav_timeout", 32'(dav_), 32'd0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("count", 32'(count), 32'(e));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("dav_hold", 32'(dav_), 32'd0);
            check("count_hold", 32'(count), 32'(e));
        end
        rfd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("soc_during_ack", 32'(soc_x), 32'd0);
        end
        check("dav_release", 32'(dav_), 32'd1);
        rfd = 1'b1;
        @(negedge clock);
        check("count_kept", 32'(count), 32'(e));
    endtask

    task automatic run_batch(input int lag, input int hold);
        int hits;
        hits = 0;
        for (int i = 0; i < 4; i++) hits += ref_inside(px[i], py[i]);
        exp_q.push_back(8'(hits));
        for (int i = 0; i < 4; i++) sample_pt(px[i], py[i], (i < 2) ? lag : 0);
        finish_batch(hold);
    endtask

    // Converter model for the 255-sample instance
    always @(negedge clock) begin
        if (en_b) begin
            if (soc_x_b && eoc_x_b) begin
                eoc_x_b = 1'b0;
                eoc_y_b = 1'b0;
            end else if (!eoc_x_b) begin
                eoc_x_b = 1'b1;
                eoc_y_b = 1'b1;
            end
        end
    end

    initial begin
        int k;
        n_checks = 0;
        n_errors = 0;
        reset_ = 1'b0;
        eoc_x = 1'b1; eoc_y = 1'b1; x = '0; y = '0; rfd = 1'b1;
        eoc_x_b = 1'b1; eoc_y_b = 1'b1; x_b = 8'd50; y_b = 8'd0; rfd_b = 1'b1; en_b = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_soc", 32'(soc_x), 32'd0);
        check("rst_dav", 32'(dav_), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        reset_ = 1'b1;

        // Mixed points: two inside, two in both figures
        px = '{0, 48, -60, 10};     py = '{0, 48, 0, 10};
        run_batch(0, 0);
        // Inclusive boundaries and the -128 corner
        px = '{48, 48, -128, 0};    py = '{16, 17, -128, 0};
        run_batch(0, 2);
        // eoc_x leads by 5 clocks; consumer holds rfd=1 for 10 clocks
        px = '{-60, 50, 20, -30};   py = '{0, 5, -30, -40};
        run_batch(5, 10);

        // Reset after two inside samples; the partial batch must vanish
        sample_pt(48, 48, 0);
        sample_pt(-60, 0, 0);
        #2 reset_ = 1'b0;
        #1;
        check("midrst_soc", 32'(soc_x), 32'd0);
        check("midrst_dav", 32'(dav_), 32'd1);
        check("midrst_count", 32'(count), 32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        px = '{10, 60, -5, 0};      py = '{10, -3, -50, 64};
        run_batch(0, 0);

        // Full 255-sample batch of inside points must not wrap
        exp_b.push_back(8'd255);
        en_b = 1'b1;
        k = 0;
        while (dav_b !== 1'b0 && k < 3000) begin
            @(negedge clock);
            k++;
        end
        check("b_dav_timeout", 32'(dav_b), 32'd0);
        check("b_count", 32'(count_b), 32'(exp_b.pop_front()));
        en_b = 1'b0;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
